// File: rtl/uart_tx_queue.sv
// uart_tx_queue: 16-byte FIFO feeding a UART transmitter one byte per
// start pulse, with a sticky overflow flag for writes into a full queue.
//
// Ports:
//   i_Clk       clock, all state on rising edge
//   i_Rst       synchronous active-low reset
//   i_fWr       producer write strobe, one byte per high cycle
//   i_WrData    byte written when i_fWr=1
//   o_fFull     queue holds 16 bytes
//   o_fEmpty    queue holds 0 bytes
//   o_fOvf      sticky: a write was dropped because the queue was full
//   o_fTx       one-cycle start pulse to the transmitter
//   o_TxData    byte for the transmitter, held until the next issue
//   i_fTxReady  transmitter idle (level)
//   i_fTxDone   transmitter stop-bit-complete pulse
//   o_Level     queue fill level 0..16 (only with UART_TX_QUEUE_LEVEL_EN)
//
// Build option: define UART_TX_QUEUE_LEVEL_EN to add the o_Level port.

module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fWr,
  input  logic [7:0] i_WrData,
  output logic       o_fFull,
  output logic       o_fEmpty,
  output logic       o_fOvf,
  output logic       o_fTx,
  output logic [7:0] o_TxData,
`ifdef UART_TX_QUEUE_LEVEL_EN
  output logic [PTR_W:0] o_Level,
`endif
  input  logic       i_fTxReady,
  input  logic       i_fTxDone
);

  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    WAIT_DONE
  } state_t;

  state_t state;
  state_t nextState;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;

  logic fTx;
  logic [7:0] txData;
  logic fOvf;

  logic isFull;
  logic isEmpty;
  logic issue;
  logic wrOk;
  logic ovfHit;

  assign isFull  = (count == CNT_W'(DEPTH));
  assign isEmpty = (count == '0);

  // A pop at the same edge frees a slot, so a write
  // into a full queue is still accepted then.
  assign wrOk   = i_fWr && (!isFull || issue);
  assign ovfHit = i_fWr && isFull && !issue;

  always_comb begin
    nextState = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!isEmpty && i_fTxReady) begin
          issue     = 1'b1;
          nextState = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_fTxDone) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    countNext = count;
    unique case ({wrOk, issue})
      2'b10:   countNext = count + CNT_W'(1);
      2'b01:   countNext = count - CNT_W'(1);
      default: countNext = count;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state  <= IDLE;
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      fTx    <= 1'b0;
      txData <= 8'h00;
      fOvf   <= 1'b0;
    end else begin
      state <= nextState;
      count <= countNext;
      fTx   <= issue;
      if (issue) begin
        txData <= mem[rdPtr];
        rdPtr  <= rdPtr + PTR_W'(1);
      end
      if (wrOk) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (ovfHit) begin
        fOvf <= 1'b1;
      end
    end
  end

  // Storage is not reset; count=0 keeps stale bytes
  // from ever being issued.
  always_ff @(posedge i_Clk) begin
    if (i_Rst && wrOk) begin
      mem[wrPtr] <= i_WrData;
    end
  end

  assign o_fFull  = isFull;
  assign o_fEmpty = isEmpty;
  assign o_fOvf   = fOvf;
  assign o_fTx    = fTx;
  assign o_TxData = txData;

`ifdef UART_TX_QUEUE_LEVEL_EN
  assign o_Level = count;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for uart_tx_queue with a
// queue-based reference model and randomized traffic.

module tb_uart_tx_queue;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_fWr = 1'b0;
  logic [7:0] i_WrData = 8'h00;
  logic       i_fTxReady = 1'b0;
  logic       i_fTxDone = 1'b0;
  logic       o_fFull;
  logic       o_fEmpty;
  logic       o_fOvf;
  logic       o_fTx;
  logic [7:0] o_TxData;
`ifdef UART_TX_QUEUE_LEVEL_EN
  logic [4:0] o_Level;
`endif

  int checks = 0;
  int failures = 0;

  uart_tx_queue dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_fWr(i_fWr),
    .i_WrData(i_WrData),
    .o_fFull(o_fFull),
    .o_fEmpty(o_fEmpty),
    .o_fOvf(o_fOvf),
    .o_fTx(o_fTx),
    .o_TxData(o_TxData),
`ifdef UART_TX_QUEUE_LEVEL_EN
    .o_Level(o_Level),
`endif
    .i_fTxReady(i_fTxReady),
    .i_fTxDone(i_fTxDone)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference model: a byte queue plus a transmitter-busy flag.
  logic [7:0] mq [$];
  logic [7:0] expQ [$];
  bit         busy = 0;
  bit         mOvf = 0;
  bit         mPulse = 0;
  logic [7:0] mData = 8'h00;
  bit         started = 0;

  always @(posedge i_Clk) begin
    bit pop;
    bit wasFull;
    if (!i_Rst) begin
      mq.delete();
      busy    = 0;
      mOvf    = 0;
      mPulse  = 0;
      mData   = 8'h00;
      started = 1;
    end else begin
      wasFull = (mq.size() == 16);
      pop = !busy && (mq.size() != 0) && i_fTxReady;
      mPulse = pop;
      if (pop) begin
        mData = mq.pop_front();
        expQ.push_back(mData);
        busy = 1;
      end else if (busy && i_fTxDone) begin
        busy = 0;
      end
      if (i_fWr) begin
        if (!wasFull || pop) mq.push_back(i_WrData);
        else mOvf = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare flags every cycle; pop the scoreboard on each pulse.
  always @(negedge i_Clk) begin
    if (started) begin
      chk("fTx", {7'd0, o_fTx}, {7'd0, mPulse});
      chk("fEmpty", {7'd0, o_fEmpty}, {7'd0, mq.size() == 0});
      chk("fFull", {7'd0, o_fFull}, {7'd0, mq.size() == 16});
      chk("fOvf", {7'd0, o_fOvf}, {7'd0, mOvf});
      chk("TxDataHold", o_TxData, mData);
`ifdef UART_TX_QUEUE_LEVEL_EN
      chk("Level", {3'd0, o_Level}, 8'(mq.size()));
`endif
      if (o_fTx === 1'b1) begin
        if (expQ.size() == 0) begin
          chk("unexpectedTx", o_TxData, 8'hxx);
        end else begin
          chk("TxData", o_TxData, expQ.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic wr, input logic [7:0] d,
                     input logic rdy, input logic dn,
                     input logic rst = 1'b1);
    i_fWr = wr;
    i_WrData = d;
    i_fTxReady = rdy;
    i_fTxDone = dn;
    i_Rst = rst;
    @(negedge i_Clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  initial begin
    @(negedge i_Clk);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rstEmpty", {7'd0, o_fEmpty}, 8'h01);
    chk("rstFull", {7'd0, o_fFull}, 8'h00);
    chk("rstTx", {7'd0, o_fTx}, 8'h00);
    chk("rstData", o_TxData, 8'h00);

    // Single byte latency: pulse in cycle W+2, one cycle wide.
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("latW1", {7'd0, o_fTx}, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("latW2", {7'd0, o_fTx}, 8'h01);
    chk("latData", o_TxData, 8'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("latW3", {7'd0, o_fTx}, 8'h00);
    chk("latEmpty", {7'd0, o_fEmpty}, 8'h01);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fillFull", {7'd0, o_fFull}, 8'h01);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovfSet", {7'd0, o_fOvf}, 8'h01);
    chk("ovfFull", {7'd0, o_fFull}, 8'h01);
    drain(17);
    chk("drainEmpty", {7'd0, o_fEmpty}, 8'h01);

    // Full queue: write coincides with issue.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("simulNoOvf", {7'd0, o_fOvf}, 8'h00);
    chk("simulFull", {7'd0, o_fFull}, 8'h01);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    drain(17);

    // Reset while in WAIT_DONE with bytes queued; write during reset ignored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    chk("midRstEmpty", {7'd0, o_fEmpty}, 8'h01);
    chk("midRstTx", {7'd0, o_fTx}, 8'h00);
    chk("midRstOvf", {7'd0, o_fOvf}, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 1'(i == 1));

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 9) < 6), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 299) != 0));
    end
    drain(17);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL leftoverExpected act=%0d exp=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
